// File: rtl/int_svc_master_if.sv
// Register-bus link between the interrupt service sequencer (master) and the register file (slave).
// Latency: none; this is wiring only, and all timing belongs to the endpoints.
// Backpressure: the master holds req/addr/we/wdata until the slave raises gnt in the same cycle.
interface int_svc_master_if #(
    parameter int MM_ADDR_WIDTH = 8,
    parameter int MM_DATA_WIDTH = 16
) ();
    logic                     mm_m_req;
    logic                     mm_m_gnt;
    logic [MM_ADDR_WIDTH-1:0] mm_m_addr;
    logic [MM_DATA_WIDTH-1:0] mm_m_wdata;
    logic                     mm_m_we;
    logic [MM_DATA_WIDTH-1:0] mm_m_rdata;

    modport master (
        output mm_m_req, mm_m_addr, mm_m_wdata, mm_m_we,
        input  mm_m_gnt, mm_m_rdata
    );

    modport slave (
        input  mm_m_req, mm_m_addr, mm_m_wdata, mm_m_we,
        output mm_m_gnt, mm_m_rdata
    );
endinterface

// File: rtl/int_svc_master.sv
// Interrupt service sequencer: reads pending, emits one event ID by fixed priority, clears the source, and programs the mask.
// Latency: 3 cycles from the interrupt line falling to the pending read request; the event is valid 1 cycle after the read grant.
// Backpressure: bus accesses hold until gnt; the event holds until evt_ready_i; mask requests queue until the next IDLE.
module int_svc_master #(
    parameter int                     MM_ADDR_WIDTH    = 8,
    parameter int                     MM_DATA_WIDTH    = 16,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_PND = 'h04,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_CLR = 'h06,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_MSK = 'h08,
    parameter logic [MM_DATA_WIDTH-1:0] INIT_MSK         = 'h0000,
    parameter int                     SETTLE_CYCLES    = 5
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_n_i,
    input  logic                 sys_int_n_i,
    int_svc_master_if.master     mm,
    input  logic                 msk_wr_i,
    input  logic [15:0]          msk_data_i,
    output logic                 evt_valid_o,
    output logic [1:0]           evt_id_o,
    input  logic                 evt_ready_i,
    output logic [7:0]           spur_cnt_o,
    output logic                 busy_o
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR_MSK,
        S_RD_PND,
        S_EVT,
        S_WR_CLR,
        S_SETTLE
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               sync_q, sync_d;
    logic                     msk_pend_q, msk_pend_d;
    logic [15:0]              msk_buf_q, msk_buf_d;
    logic [7:0]               spur_q, spur_d;
    logic [1:0]               evt_id_q, evt_id_d;
    logic                     evt_valid_q, evt_valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [MM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MM_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                     int_n_s;
    logic                     acc_done;
    logic [3:0]               pnd;
    logic [1:0]               pnd_sel;
    logic [MM_DATA_WIDTH-1:0] clr_dat;
    logic                     unused_rdata_hi;

    assign int_n_s  = sync_q[1];
    assign acc_done = req_q & mm.mm_m_gnt;
    assign pnd      = mm.mm_m_rdata[3:0];
    // Pending bits above the four sources are reserved and ignored.
    assign unused_rdata_hi = ^mm.mm_m_rdata[MM_DATA_WIDTH-1:4];

    // Fixed priority: watchdog (bit 3) first, then 0, 1, 2.
    always_comb begin
        pnd_sel = 2'd2;
        if (pnd[3])      pnd_sel = 2'd3;
        else if (pnd[0]) pnd_sel = 2'd0;
        else if (pnd[1]) pnd_sel = 2'd1;
    end

    // Next-state, bookkeeping and bus-output selection for the sequencer.
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], sys_int_n_i};
        msk_pend_d = msk_pend_q;
        msk_buf_d  = msk_buf_q;
        spur_d     = spur_q;
        evt_id_d   = evt_id_q;
        cnt_d      = cnt_q;
        clr_dat    = '0;
        clr_dat[evt_id_q] = 1'b1;

        if (msk_wr_i) begin
            msk_pend_d = 1'b1;
            msk_buf_d  = msk_data_i;
        end

        case (state_q)
            S_INIT: begin
                if (acc_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (msk_pend_q)    state_d = S_WR_MSK;
                else if (!int_n_s) state_d = S_RD_PND;
            end
            S_WR_MSK: begin
                if (acc_done) begin
                    state_d = S_IDLE;
                    // A request that landed while this write was in flight must not be lost.
                    msk_pend_d = msk_wr_i || (MM_DATA_WIDTH'(msk_buf_q) != wdata_q);
                end
            end
            S_RD_PND: begin
                if (acc_done) begin
                    if (pnd == 4'h0) begin
                        if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = S_SETTLE;
                    end else begin
                        evt_id_d = pnd_sel;
                        state_d  = S_EVT;
                    end
                end
            end
            S_EVT: begin
                if (evt_ready_i) state_d = S_WR_CLR;
            end
            S_WR_CLR: begin
                if (acc_done) begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_INIT;
        endcase

        // Bus outputs are registered from the next state; an ungranted access holds its values.
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        if (req_q && !acc_done) begin
            req_d   = 1'b1;
            we_d    = we_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end else begin
            case (state_d)
                S_INIT: begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = REG_ADDR_INT_MSK;
                    wdata_d = INIT_MSK;
                end
                S_WR_MSK: begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = REG_ADDR_INT_MSK;
                    wdata_d = MM_DATA_WIDTH'(msk_buf_q);
                end
                S_RD_PND: begin
                    req_d  = 1'b1;
                    addr_d = REG_ADDR_INT_PND;
                end
                S_WR_CLR: begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = REG_ADDR_INT_CLR;
                    wdata_d = clr_dat;
                end
                default: ;
            endcase
        end

        evt_valid_d = (state_d == S_EVT);
    end

    // State and output registers; reset restarts from the mask initialisation write.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT;
            sync_q      <= 2'b11;
            msk_pend_q  <= 1'b0;
            msk_buf_q   <= '0;
            spur_q      <= '0;
            evt_id_q    <= '0;
            evt_valid_q <= 1'b0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            msk_pend_q  <= msk_pend_d;
            msk_buf_q   <= msk_buf_d;
            spur_q      <= spur_d;
            evt_id_q    <= evt_id_d;
            evt_valid_q <= evt_valid_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mm.mm_m_req   = req_q;
    assign mm.mm_m_we    = we_q;
    assign mm.mm_m_addr  = addr_q;
    assign mm.mm_m_wdata = wdata_q;
    assign evt_valid_o   = evt_valid_q;
    assign evt_id_o      = evt_id_q;
    assign spur_cnt_o    = spur_q;
    assign busy_o        = (state_q != S_IDLE);
endmodule

// File: tb/tb_int_svc_master.sv
// Directed bench for int_svc_master with a simple register-file slave model on the bus.
// Latency: checks the interrupt-to-request, read-to-event and handshake-to-clear cycle counts.
// Backpressure: exercises a held grant, a held evt_ready_i, and mask requests queued behind an event.
module tb_int_svc_master;
    logic        clk = 1'b0;
    logic        rst_n, sys_int_n, msk_wr, evt_ready, evt_valid, busy, gnt;
    logic [15:0] msk_data, pnd_val;
    logic [1:0]  evt_id;
    logic [7:0]  spur;
    int          total = 0;
    int          bad   = 0;
    int          n_rd  = 0;
    int          n_wr  = 0;
    int          n_evt = 0;
    int          base_rd, base_evt;
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_dat[$];

    always #5 clk = ~clk;

    int_svc_master_if bus ();

    assign bus.mm_m_gnt   = gnt;
    assign bus.mm_m_rdata = (bus.mm_m_addr == 8'h04) ? pnd_val : 16'h0000;

    int_svc_master dut (
        .clk_sys_i   (clk),
        .rst_n_i     (rst_n),
        .sys_int_n_i (sys_int_n),
        .mm          (bus),
        .msk_wr_i    (msk_wr),
        .msk_data_i  (msk_data),
        .evt_valid_o (evt_valid),
        .evt_id_o    (evt_id),
        .evt_ready_i (evt_ready),
        .spur_cnt_o  (spur),
        .busy_o      (busy)
    );

    // Bus monitor: logs every completed access and counts cycles with an event pending.
    always @(posedge clk) begin
        if (bus.mm_m_req && gnt) begin
            if (bus.mm_m_we) begin
                wr_addr.push_back(bus.mm_m_addr);
                wr_dat.push_back(bus.mm_m_wdata);
                n_wr <= n_wr + 1;
            end else begin
                n_rd <= n_rd + 1;
            end
        end
        if (evt_valid) n_evt <= n_evt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_evt(input string tag);
        int i = 0;
        while (!evt_valid && i < 100) begin
            tick();
            i++;
        end
        chk({tag, "_evt_wait"}, 32'(evt_valid), 32'd1);
    endtask

    task automatic wait_wr(input int target, input string tag);
        int i = 0;
        while (n_wr < target && i < 100) begin
            tick();
            i++;
        end
        chk({tag, "_wr_wait"}, 32'(n_wr), 32'(target));
    endtask

    task automatic wait_rd(input int target, input int budget, input string tag);
        int i = 0;
        while (n_rd < target && i < budget) begin
            tick();
            i++;
        end
        chk({tag, "_rd_wait"}, 32'(n_rd), 32'(target));
    endtask

    initial begin
        int i;
        rst_n = 1'b0; sys_int_n = 1'b1; msk_wr = 1'b0; msk_data = 16'h0;
        evt_ready = 1'b0; pnd_val = 16'h0; gnt = 1'b1;
        tick(3);
        chk("rst_req",   32'(bus.mm_m_req), 32'd0);
        chk("rst_we",    32'(bus.mm_m_we), 32'd0);
        chk("rst_addr",  32'(bus.mm_m_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mm_m_wdata), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id",    32'(evt_id), 32'd0);
        chk("rst_spur",  32'(spur), 32'd0);
        chk("rst_busy",  32'(busy), 32'd1);

        // INIT writes the initial mask once, then the sequencer idles.
        rst_n = 1'b1;
        i = 0;
        while (busy && i < 20) begin tick(); i++; end
        chk("init_idle",  32'(busy), 32'd0);
        chk("init_nwr",   32'(n_wr), 32'd1);
        chk("init_addr",  32'(wr_addr[0]), 32'h08);
        chk("init_dat",   32'(wr_dat[0]), 32'h0000);
        chk("init_req0",  32'(bus.mm_m_req), 32'd0);

        // Pending 0x5: source 0 first, then source 2 on the re-read.
        evt_ready = 1'b1; pnd_val = 16'h0005; sys_int_n = 1'b0;
        tick(2);
        chk("lat_req_early", 32'(bus.mm_m_req), 32'd0);
        tick();
        chk("lat_req",  32'(bus.mm_m_req), 32'd1);
        chk("lat_addr", 32'(bus.mm_m_addr), 32'h04);
        chk("lat_we",   32'(bus.mm_m_we), 32'd0);
        tick();
        chk("s1_valid", 32'(evt_valid), 32'd1);
        chk("s1_id",    32'(evt_id), 32'd0);
        tick();
        chk("s1_clr_req",  32'(bus.mm_m_req), 32'd1);
        chk("s1_clr_we",   32'(bus.mm_m_we), 32'd1);
        chk("s1_clr_addr", 32'(bus.mm_m_addr), 32'h06);
        chk("s1_clr_dat",  32'(bus.mm_m_wdata), 32'h0001);
        pnd_val = 16'h0004;
        wait_evt("s1b");
        chk("s1b_id", 32'(evt_id), 32'd2);
        wait_wr(3, "s1b");
        chk("s1b_clr_addr", 32'(wr_addr[2]), 32'h06);
        chk("s1b_clr_dat",  32'(wr_dat[2]), 32'h0004);
        sys_int_n = 1'b1; pnd_val = 16'h0;
        tick(4);
        chk("settle_busy", 32'(busy), 32'd1);
        tick();
        chk("settle_done", 32'(busy), 32'd0);

        // Pending 0x9: watchdog wins over source 0; consumer stalls first.
        evt_ready = 1'b0; pnd_val = 16'h0009; sys_int_n = 1'b0;
        wait_evt("s2");
        chk("s2_id", 32'(evt_id), 32'd3);
        tick(3);
        chk("s2_hold_valid", 32'(evt_valid), 32'd1);
        chk("s2_hold_id",    32'(evt_id), 32'd3);
        chk("s2_hold_nowr",  32'(n_wr), 32'd3);
        pnd_val = 16'h0001; evt_ready = 1'b1;
        wait_wr(4, "s2");
        chk("s2_clr_addr", 32'(wr_addr[3]), 32'h06);
        chk("s2_clr_dat",  32'(wr_dat[3]), 32'h0008);
        wait_evt("s2b");
        chk("s2b_id", 32'(evt_id), 32'd0);
        wait_wr(5, "s2b");
        chk("s2b_clr_dat", 32'(wr_dat[4]), 32'h0001);
        sys_int_n = 1'b1; pnd_val = 16'h0;
        tick(10);

        // Spurious interrupts: no event, no write, counter saturates.
        base_rd = n_rd; base_evt = n_evt; sys_int_n = 1'b0;
        wait_rd(base_rd + 1, 20, "spur1");
        chk("spur_first", 32'(spur), 32'd1);
        wait_rd(base_rd + 256, 4000, "spur256");
        chk("spur_sat_256", 32'(spur), 32'd255);
        wait_rd(base_rd + 260, 100, "spur260");
        chk("spur_sat_260", 32'(spur), 32'd255);
        sys_int_n = 1'b1;
        tick(15);
        chk("spur_no_evt", 32'(n_evt), 32'(base_evt));
        chk("spur_no_wr",  32'(n_wr), 32'd5);

        // Grant held low for 10 cycles during the pending read.
        gnt = 1'b0; pnd_val = 16'h0002; base_rd = n_rd; sys_int_n = 1'b0;
        i = 0;
        while (!bus.mm_m_req && i < 20) begin tick(); i++; end
        chk("s4_req_seen", 32'(bus.mm_m_req), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("s4_req_hold",  32'(bus.mm_m_req), 32'd1);
            chk("s4_addr_hold", 32'(bus.mm_m_addr), 32'h04);
            tick();
        end
        chk("s4_no_read", 32'(n_rd), 32'(base_rd));
        gnt = 1'b1;
        tick();
        chk("s4_one_read", 32'(n_rd), 32'(base_rd + 1));
        chk("s4_valid",    32'(evt_valid), 32'd1);
        chk("s4_id",       32'(evt_id), 32'd1);
        wait_wr(6, "s4");
        chk("s4_clr_dat", 32'(wr_dat[5]), 32'h0002);
        sys_int_n = 1'b1; pnd_val = 16'h0;
        tick(10);

        // Mask request during EVT is serviced after the clear and settle.
        evt_ready = 1'b0; pnd_val = 16'h0001; sys_int_n = 1'b0;
        wait_evt("s5");
        msk_data = 16'h800F; msk_wr = 1'b1;
        tick();
        msk_wr = 1'b0; msk_data = 16'h0;
        tick(2);
        chk("s5_hold_valid", 32'(evt_valid), 32'd1);
        chk("s5_hold_nowr",  32'(n_wr), 32'd6);
        evt_ready = 1'b1;
        wait_wr(7, "s5clr");
        chk("s5_clr_addr", 32'(wr_addr[6]), 32'h06);
        chk("s5_clr_dat",  32'(wr_dat[6]), 32'h0001);
        sys_int_n = 1'b1; pnd_val = 16'h0;
        wait_wr(8, "s5msk");
        chk("s5_msk_addr", 32'(wr_addr[7]), 32'h08);
        chk("s5_msk_dat",  32'(wr_dat[7]), 32'h800F);
        tick(10);
        chk("s5_single_msk", 32'(n_wr), 32'd8);

        // Reset during EVT drops the event and discards the queued mask request.
        evt_ready = 1'b0; pnd_val = 16'h0008; sys_int_n = 1'b0;
        wait_evt("s6");
        msk_data = 16'h1234; msk_wr = 1'b1;
        tick();
        msk_wr = 1'b0; msk_data = 16'h0;
        chk("s6_valid_pre", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_valid_rst", 32'(evt_valid), 32'd0);
        chk("s6_busy_rst",  32'(busy), 32'd1);
        chk("s6_req_rst",   32'(bus.mm_m_req), 32'd0);
        sys_int_n = 1'b1; pnd_val = 16'h0;
        tick(2);
        rst_n = 1'b1;
        wait_wr(9, "s6init");
        chk("s6_init_addr", 32'(wr_addr[8]), 32'h08);
        chk("s6_init_dat",  32'(wr_dat[8]), 32'h0000);
        tick(20);
        chk("s6_pend_cleared", 32'(n_wr), 32'd9);
        chk("s6_idle",         32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
